// File: rtl/can_frame_rx.sv
// can_frame_rx: bit-level CAN 2.0A receiver. Synchronizes the bus pin,
// recovers bit timing with hard resync, removes stuff bits, decodes standard
// data/remote frames, checks CRC15 and form, drives the ACK slot for good
// frames and presents each frame as a one-cycle-valid parallel word.
`timescale 1ns/1ps
module can_frame_rx #(
    parameter int BAUD_DIV  = 32,
    parameter int SAMPLE_PT = 22,
    parameter int ACK_EN    = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        can_rx,
    output logic        can_tx,
    output logic        rx_valid,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        rx_err,
    output logic [1:0]  rx_err_code,
    output logic        busy
);

    localparam logic [3:0] ST_WAIT_IDLE = 4'd0;
    localparam logic [3:0] ST_IDLE      = 4'd1;
    localparam logic [3:0] ST_ARB       = 4'd2;
    localparam logic [3:0] ST_CTRL      = 4'd3;
    localparam logic [3:0] ST_DATA      = 4'd4;
    localparam logic [3:0] ST_CRC       = 4'd5;
    localparam logic [3:0] ST_CRC_DEL   = 4'd6;
    localparam logic [3:0] ST_ACK       = 4'd7;
    localparam logic [3:0] ST_ACK_DEL   = 4'd8;
    localparam logic [3:0] ST_EOF       = 4'd9;

    localparam logic [1:0] ERR_STUFF = 2'b01;
    localparam logic [1:0] ERR_CRC   = 2'b10;
    localparam logic [1:0] ERR_FORM  = 2'b11;

    // One CRC15 step (polynomial 0x4599) for a single destuffed bit.
    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        crc15_step = {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    logic        sync1_q, rxs_q, rxs_prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  state_q, state_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  stuff_cnt_q, stuff_cnt_d;
    logic        last_bit_q, last_bit_d;
    logic [14:0] crc_q, crc_d;
    logic [13:0] crc_rx_q, crc_rx_d;
    logic        crc_ok_q, crc_ok_d;
    logic [10:0] id_q, id_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [3:0]  nbytes_q, nbytes_d;
    logic [63:0] data_q, data_d;
    logic        can_tx_q, can_tx_d;
    logic        busy_q, busy_d;
    logic        rx_valid_q, rx_valid_d;
    logic [10:0] rx_id_q, rx_id_d;
    logic        rx_rtr_q, rx_rtr_d;
    logic [3:0]  rx_dlc_q, rx_dlc_d;
    logic [63:0] rx_data_q, rx_data_d;
    logic        rx_err_q, rx_err_d;
    logic [1:0]  rx_err_code_q, rx_err_code_d;
    logic        err_s;
    logic [1:0]  err_code_s;

    // Resync is suppressed while we pull the bus for ACK (our own edge).
    logic resync_s, wrap_s, sample_s, ack_arm_s, data_last_s;
    logic [3:0] dlc_full_s, nbytes_s;
    assign resync_s    = rxs_prev_q & ~rxs_q & can_tx_q;
    assign wrap_s      = (cnt_q == 8'(BAUD_DIV - 1));
    assign sample_s    = (cnt_q == 8'(SAMPLE_PT)) & ~resync_s;
    assign ack_arm_s   = (state_q == ST_ACK) & crc_ok_q & (ACK_EN != 0);
    assign dlc_full_s  = {dlc_q[2:0], rxs_q};
    assign nbytes_s    = rtr_q ? 4'd0 : ((dlc_full_s > 4'd8) ? 4'd8 : dlc_full_s);
    assign data_last_s = (bit_cnt_q == ({nbytes_q, 3'b000} - 7'd1));

    // Two-flop synchronizer on the bus pin plus one stage of edge history.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= can_rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Bit timing, destuffing, field decode, CRC/form checks and ACK drive.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        stuff_cnt_d   = stuff_cnt_q;
        last_bit_d    = last_bit_q;
        crc_d         = crc_q;
        crc_rx_d      = crc_rx_q;
        crc_ok_d      = crc_ok_q;
        id_d          = id_q;
        rtr_d         = rtr_q;
        dlc_d         = dlc_q;
        nbytes_d      = nbytes_q;
        data_d        = data_q;
        busy_d        = busy_q;
        rx_valid_d    = 1'b0;
        rx_id_d       = rx_id_q;
        rx_rtr_d      = rx_rtr_q;
        rx_dlc_d      = rx_dlc_q;
        rx_data_d     = rx_data_q;
        rx_err_d      = 1'b0;
        rx_err_code_d = rx_err_code_q;
        err_s         = 1'b0;
        err_code_s    = 2'b00;

        if (resync_s || wrap_s) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // ACK drive starts at the wrap opening the ACK bit, ends at the next.
        if (wrap_s) begin
            can_tx_d = ~ack_arm_s;
        end else begin
            can_tx_d = can_tx_q;
        end

        if (sample_s) begin
            case (state_q)
                ST_WAIT_IDLE: begin
                    if (!rxs_q) begin
                        bit_cnt_d = 7'd0;
                    end else if (bit_cnt_q == 7'd10) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 7'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_d     = ST_ARB;
                        busy_d      = 1'b1;
                        bit_cnt_d   = 7'd0;
                        stuff_cnt_d = 3'd1;
                        last_bit_d  = 1'b0;
                        crc_d       = 15'd0;
                        crc_ok_d    = 1'b0;
                        data_d      = 64'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARB, ST_CTRL, ST_DATA, ST_CRC: begin
                    if (stuff_cnt_q == 3'd5) begin
                        // Stuff bit: must differ from the run, then discarded.
                        if (rxs_q == last_bit_q) begin
                            err_s      = 1'b1;
                            err_code_s = ERR_STUFF;
                        end else begin
                            stuff_cnt_d = 3'd1;
                            last_bit_d  = rxs_q;
                        end
                    end else begin
                        if (rxs_q == last_bit_q) begin
                            stuff_cnt_d = stuff_cnt_q + 3'd1;
                        end else begin
                            stuff_cnt_d = 3'd1;
                        end
                        last_bit_d = rxs_q;
                        if (state_q != ST_CRC) begin
                            crc_d = crc15_step(crc_q, rxs_q);
                        end else begin
                            crc_d = crc_q;
                        end
                        case (state_q)
                            ST_ARB: begin
                                if (bit_cnt_q < 7'd11) begin
                                    id_d      = {id_q[9:0], rxs_q};
                                    bit_cnt_d = bit_cnt_q + 7'd1;
                                end else begin
                                    rtr_d     = rxs_q;
                                    bit_cnt_d = 7'd0;
                                    state_d   = ST_CTRL;
                                end
                            end
                            ST_CTRL: begin
                                if (bit_cnt_q == 7'd0) begin
                                    if (rxs_q) begin
                                        err_s      = 1'b1;
                                        err_code_s = ERR_FORM;
                                    end else begin
                                        bit_cnt_d = 7'd1;
                                    end
                                end else if (bit_cnt_q == 7'd5) begin
                                    dlc_d     = dlc_full_s;
                                    nbytes_d  = nbytes_s;
                                    bit_cnt_d = 7'd0;
                                    state_d   = (nbytes_s == 4'd0) ? ST_CRC : ST_DATA;
                                end else begin
                                    // Bit 1 is r0 (ignored); bits 2..4 feed the DLC.
                                    dlc_d     = (bit_cnt_q >= 7'd2) ? dlc_full_s : dlc_q;
                                    bit_cnt_d = bit_cnt_q + 7'd1;
                                end
                            end
                            ST_DATA: begin
                                data_d[~bit_cnt_q[5:0]] = rxs_q;
                                if (data_last_s) begin
                                    bit_cnt_d = 7'd0;
                                    state_d   = ST_CRC;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 7'd1;
                                end
                            end
                            ST_CRC: begin
                                if (bit_cnt_q == 7'd14) begin
                                    crc_ok_d  = ({crc_rx_q, rxs_q} == crc_q);
                                    bit_cnt_d = 7'd0;
                                    state_d   = ST_CRC_DEL;
                                end else begin
                                    crc_rx_d  = {crc_rx_q[12:0], rxs_q};
                                    bit_cnt_d = bit_cnt_q + 7'd1;
                                end
                            end
                            default: begin
                                state_d = ST_WAIT_IDLE;
                            end
                        endcase
                    end
                end
                ST_CRC_DEL: begin
                    if (!rxs_q) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_FORM;
                    end else if (!crc_ok_q) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_CRC;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_d = ST_ACK_DEL;
                end
                ST_ACK_DEL: begin
                    if (!rxs_q) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_FORM;
                    end else begin
                        state_d   = ST_EOF;
                        bit_cnt_d = 7'd0;
                    end
                end
                ST_EOF: begin
                    if (!rxs_q) begin
                        err_s      = 1'b1;
                        err_code_s = ERR_FORM;
                    end else if (bit_cnt_q == 7'd6) begin
                        state_d    = ST_IDLE;
                        bit_cnt_d  = 7'd0;
                        busy_d     = 1'b0;
                        rx_valid_d = 1'b1;
                        rx_id_d    = id_q;
                        rx_rtr_d   = rtr_q;
                        rx_dlc_d   = dlc_q;
                        rx_data_d  = data_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
                default: begin
                    state_d   = ST_WAIT_IDLE;
                    bit_cnt_d = 7'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (err_s) begin
            state_d       = ST_WAIT_IDLE;
            bit_cnt_d     = 7'd0;
            busy_d        = 1'b0;
            can_tx_d      = 1'b1;
            rx_err_d      = 1'b1;
            rx_err_code_d = err_code_s;
        end else begin
            rx_err_code_d = rx_err_code_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q         <= 8'd0;
            state_q       <= ST_WAIT_IDLE;
            bit_cnt_q     <= 7'd0;
            stuff_cnt_q   <= 3'd0;
            last_bit_q    <= 1'b1;
            crc_q         <= 15'd0;
            crc_rx_q      <= 14'd0;
            crc_ok_q      <= 1'b0;
            id_q          <= 11'd0;
            rtr_q         <= 1'b0;
            dlc_q         <= 4'd0;
            nbytes_q      <= 4'd0;
            data_q        <= 64'd0;
            can_tx_q      <= 1'b1;
            busy_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_id_q       <= 11'd0;
            rx_rtr_q      <= 1'b0;
            rx_dlc_q      <= 4'd0;
            rx_data_q     <= 64'd0;
            rx_err_q      <= 1'b0;
            rx_err_code_q <= 2'b00;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            stuff_cnt_q   <= stuff_cnt_d;
            last_bit_q    <= last_bit_d;
            crc_q         <= crc_d;
            crc_rx_q      <= crc_rx_d;
            crc_ok_q      <= crc_ok_d;
            id_q          <= id_d;
            rtr_q         <= rtr_d;
            dlc_q         <= dlc_d;
            nbytes_q      <= nbytes_d;
            data_q        <= data_d;
            can_tx_q      <= can_tx_d;
            busy_q        <= busy_d;
            rx_valid_q    <= rx_valid_d;
            rx_id_q       <= rx_id_d;
            rx_rtr_q      <= rx_rtr_d;
            rx_dlc_q      <= rx_dlc_d;
            rx_data_q     <= rx_data_d;
            rx_err_q      <= rx_err_d;
            rx_err_code_q <= rx_err_code_d;
        end
    end

    assign can_tx      = can_tx_q;
    assign busy        = busy_q;
    assign rx_valid    = rx_valid_q;
    assign rx_id       = rx_id_q;
    assign rx_rtr      = rx_rtr_q;
    assign rx_dlc      = rx_dlc_q;
    assign rx_data     = rx_data_q;
    assign rx_err      = rx_err_q;
    assign rx_err_code = rx_err_code_q;

endmodule

// File: tb/tb_can_frame_rx.sv
// tb_can_frame_rx: drives bit-accurate CAN frames onto a wired-AND bus shared
// with the receiver's ACK output and scores decoded frames/errors against a
// queue of expected results.
`timescale 1ns/1ps
module tb_can_frame_rx;

    localparam real NOM_NS  = 640.0;   // 32 clocks of 20 ns
    localparam real FAST_NS = 630.4;   // -1.5 %
    localparam real SLOW_NS = 649.6;   // +1.5 %

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        tx_bit  = 1'b1;
    logic        bus_s;
    logic        can_tx, rx_valid, rx_rtr, rx_err, busy;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic [1:0]  rx_err_code;

    exp_t sb[$];
    exp_t mon_e;
    bit   frame_q[$];
    int   errors = 0;
    int   checks = 0;
    int   ack_cycles = 0;
    int   busy_hi;
    int   waited;

    assign bus_s = tx_bit & can_tx;

    always #10 sys_clk = ~sys_clk;

    can_frame_rx #(.BAUD_DIV(32), .SAMPLE_PT(22), .ACK_EN(1)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .can_rx      (bus_s),
        .can_tx      (can_tx),
        .rx_valid    (rx_valid),
        .rx_id       (rx_id),
        .rx_rtr      (rx_rtr),
        .rx_dlc      (rx_dlc),
        .rx_data     (rx_data),
        .rx_err      (rx_err),
        .rx_err_code (rx_err_code),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC15 by long division of the message augmented with 15 zeros.
    function automatic logic [14:0] crc_ref(input bit msg[$]);
        logic [15:0] r;
        bit          b;
        r = 16'd0;
        for (int i = 0; i < msg.size() + 15; i++) begin
            b = (i < msg.size()) ? msg[i] : 1'b0;
            r = {r[14:0], b};
            if (r[15]) r = r ^ 16'hC599;
        end
        return r[14:0];
    endfunction

    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                               input logic [3:0] dlc, input logic [63:0] data,
                               input bit flip_crc, input bit stuff_en, input bit crc_del_dom);
        bit          raw[$];
        logic [14:0] crc;
        int          nbits;
        bit          last;
        int          run;
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(ide);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbits = rtr ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
        for (int i = 0; i < nbits; i++) raw.push_back(data[63 - i]);
        crc = crc_ref(raw);
        if (flip_crc) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        frame_q = {};
        last = 1'b1;
        run  = 0;
        for (int i = 0; i < raw.size(); i++) begin
            frame_q.push_back(raw[i]);
            if (raw[i] == last) run++;
            else begin run = 1; last = raw[i]; end
            if (stuff_en && run == 5 && i < raw.size() - 1) begin
                frame_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        frame_q.push_back(crc_del_dom ? 1'b0 : 1'b1);  // CRC delimiter
        repeat (9) frame_q.push_back(1'b1);            // ACK, ACK delim, EOF
    endtask

    task automatic send_frame(input real bit_ns);
        @(posedge sys_clk);
        #3;
        for (int i = 0; i < frame_q.size(); i++) begin
            tx_bit = frame_q[i];
            #(bit_ns);
        end
        tx_bit = 1'b1;
        #(bit_ns * 12.0);
    endtask

    task automatic push_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data);
        exp_t e;
        e.is_err = 1'b0; e.code = 2'b00; e.id = id; e.rtr = rtr; e.dlc = dlc; e.data = data;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.code = code; e.id = 11'd0; e.rtr = 1'b0; e.dlc = 4'd0; e.data = 64'd0;
        sb.push_back(e);
    endtask

    task automatic run_good(input string tag, input logic [10:0] id, input logic rtr,
                            input logic [3:0] dlc, input logic [63:0] data, input real bit_ns);
        build_frame(id, rtr, 1'b0, dlc, data, 1'b0, 1'b1, 1'b0);
        push_frame(id, rtr, dlc, data);
        ack_cycles = 0;
        send_frame(bit_ns);
        check({tag, "_ack_len"}, 64'(ack_cycles), 64'd32);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic run_bad(input string tag, input logic [10:0] id, input logic ide,
                           input logic [3:0] dlc, input logic [63:0] data, input bit flip_crc,
                           input bit stuff_en, input bit crc_del_dom, input logic [1:0] code);
        build_frame(id, 1'b0, ide, dlc, data, flip_crc, stuff_en, crc_del_dom);
        push_err(code);
        ack_cycles = 0;
        send_frame(NOM_NS);
        check({tag, "_no_ack"}, 64'(ack_cycles), 64'd0);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: ACK-low cycle count and per-pulse comparison.
    always @(negedge sys_clk) begin
        if (can_tx === 1'b0) ack_cycles++;
        if (rx_valid === 1'b1 || rx_err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {62'd0, rx_valid, rx_err}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", 64'(rx_err), 64'(mon_e.is_err));
                check("pulse_valid", 64'(rx_valid), 64'(!mon_e.is_err));
                if (mon_e.is_err) begin
                    check("err_code", 64'(rx_err_code), 64'(mon_e.code));
                end else begin
                    check("rx_id", 64'(rx_id), 64'(mon_e.id));
                    check("rx_rtr", 64'(rx_rtr), 64'(mon_e.rtr));
                    check("rx_dlc", 64'(rx_dlc), 64'(mon_e.dlc));
                    check("rx_data", rx_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_can_tx", 64'(can_tx), 64'd1);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_err", 64'(rx_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rx_id", 64'(rx_id), 64'd0);
        check("rst_rx_data", rx_data, 64'd0);
        check("rst_err_code", 64'(rx_err_code), 64'd0);
        sys_rst = 1'b0;
        tx_bit  = 1'b1;
        #(NOM_NS * 12.0);

        // Nominal data frame
        run_good("data_123", 11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, NOM_NS);
        // Remote frame, then DLC 15 with eight bytes
        run_good("rtr_7ff", 11'h7FF, 1'b1, 4'd4, 64'd0, NOM_NS);
        run_good("dlc_f", 11'h2A5, 1'b0, 4'hF, 64'h0102_0304_0506_0708, NOM_NS);

        // CRC error then recovery with a good frame
        run_bad("crc_err", 11'h555, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 1'b1, 1'b1, 1'b0, 2'b10);
        run_good("after_crc", 11'h0F0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, NOM_NS);

        // Stuff error inside ID, dominant CRC delimiter, IDE=1
        run_bad("stuff_err", 11'h000, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 1'b0, 2'b01);
        run_bad("crc_del", 11'h321, 1'b0, 4'd1, 64'h9900_0000_0000_0000, 1'b0, 1'b1, 1'b1, 2'b11);
        run_bad("ide_err", 11'h456, 1'b1, 4'd1, 64'h1100_0000_0000_0000, 1'b0, 1'b1, 1'b0, 2'b11);

        // Bit-rate tolerance with an all-0x55 payload
        run_good("fast", 11'h1A2, 1'b0, 4'd8, 64'h5555_5555_5555_5555, FAST_NS);
        run_good("slow", 11'h1A3, 1'b0, 4'd8, 64'h5555_5555_5555_5555, SLOW_NS);

        // Three-cycle dominant glitch while idle
        @(posedge sys_clk);
        #3;
        tx_bit = 1'b0;
        #60;
        tx_bit = 1'b1;
        busy_hi = 0;
        repeat (96) begin
            @(negedge sys_clk);
            if (busy === 1'b1) busy_hi++;
        end
        check("glitch_busy", 64'(busy_hi), 64'd0);
        check("glitch_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while driving ACK: no rx_valid for that frame
        build_frame(11'h246, 1'b0, 1'b0, 4'd1, 64'h7700_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        fork
            send_frame(NOM_NS);
            begin
                waited = 0;
                while (can_tx !== 1'b0 && waited < 6000) begin
                    @(negedge sys_clk);
                    waited++;
                end
                check("ack_seen", 64'(can_tx), 64'd0);
                sys_rst = 1'b1;
                @(negedge sys_clk);
                sys_rst = 1'b0;
                check("midack_can_tx", 64'(can_tx), 64'd1);
                check("midack_busy", 64'(busy), 64'd0);
                check("midack_err_code", 64'(rx_err_code), 64'd0);
            end
        join
        check("midack_sb_empty", 64'(sb.size()), 64'd0);
        run_good("after_rst", 11'h135, 1'b0, 4'd3, 64'hC0FF_EE00_0000_0000, NOM_NS);

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
